rr_mux_stage: RTL and testbench

//   Parametrised N-input, WIDTH-bit selector with valid/ready handshake and one

---
 rtl/rr_mux_stage.sv | 87 ++++++++
 tb/tb_rr_mux_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_stage.sv
// N-input valid/ready selector with round-robin or fixed-priority arbitration
// feeding a single registered output stage that pipelines at one beat per cycle.
module rr_mux_stage #(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 4,
   parameter  int MODE  = 0,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN-1:0]       in_valid,
   input  logic [N_IN*WIDTH-1:0] in_data,
   output logic [N_IN-1:0]       in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic             w_any;
   logic [SEL_W-1:0] w_grant;
   logic [WIDTH-1:0] w_data;

   assign w_load = ~r_out_valid | out_ready;
   assign w_any  = |in_valid;

   always_comb begin
      // NOTE: default first so every path assigns w_grant; otherwise a latch is inferred.
      w_grant = '0;
      // Descending scans leave the lowest hit. In round-robin the second pass,
      // over indices at or above ptr, overrides the wrapped-around first pass.
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (in_valid[i] && (MODE != 0 || i < int'(r_ptr))) w_grant = SEL_W'(i);
      end
      if (MODE == 0) begin
         for (int i = N_IN - 1; i >= 0; i--) begin
            if (in_valid[i] && i >= int'(r_ptr)) w_grant = SEL_W'(i);
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (w_grant == SEL_W'(i)) w_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (rst_n && w_load && w_any && w_grant == SEL_W'(i)) in_ready[i] = 1'b1;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
      end else if (w_load) begin
         if (w_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_sel   <= w_grant;
            if (MODE == 0) begin
               r_ptr <= (w_grant == SEL_W'(N_IN - 1)) ? '0 : w_grant + SEL_W'(1);
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Bench for rr_mux_stage: three instances (4-in round-robin, 4-in fixed priority,
// 3-in round-robin) checked every cycle against a circular-scan reference model.
module tb_rr_mux_stage;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]  drv_valid [3];
   logic [31:0] drv_data  [3][4];
   logic        drv_ordy  [3];

   logic [3:0]  a_ready, b_ready;
   logic [2:0]  c_ready;
   logic        a_valid, b_valid, c_valid;
   logic [31:0] a_data, b_data, c_data;
   logic [1:0]  a_sel, b_sel, c_sel;

   logic [3:0]  obs_ready [3];
   logic        obs_valid [3];
   logic [31:0] obs_data  [3];
   logic [1:0]  obs_sel   [3];

   rr_mux_stage #(.WIDTH(32), .N_IN(4), .MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid[0]),
      .in_data({drv_data[0][3], drv_data[0][2], drv_data[0][1], drv_data[0][0]}),
      .in_ready(a_ready), .out_valid(a_valid), .out_ready(drv_ordy[0]),
      .out_data(a_data), .out_sel(a_sel));

   rr_mux_stage #(.WIDTH(32), .N_IN(4), .MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid[1]),
      .in_data({drv_data[1][3], drv_data[1][2], drv_data[1][1], drv_data[1][0]}),
      .in_ready(b_ready), .out_valid(b_valid), .out_ready(drv_ordy[1]),
      .out_data(b_data), .out_sel(b_sel));

   rr_mux_stage #(.WIDTH(32), .N_IN(3), .MODE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid[2][2:0]),
      .in_data({drv_data[2][2], drv_data[2][1], drv_data[2][0]}),
      .in_ready(c_ready), .out_valid(c_valid), .out_ready(drv_ordy[2]),
      .out_data(c_data), .out_sel(c_sel));

   assign obs_ready[0] = a_ready;
   assign obs_ready[1] = b_ready;
   assign obs_ready[2] = {1'b0, c_ready};
   assign obs_valid[0] = a_valid;
   assign obs_valid[1] = b_valid;
   assign obs_valid[2] = c_valid;
   assign obs_data[0]  = a_data;
   assign obs_data[1]  = b_data;
   assign obs_data[2]  = c_data;
   assign obs_sel[0]   = a_sel;
   assign obs_sel[1]   = b_sel;
   assign obs_sel[2]   = c_sel;

   // Reference model: channel count, mode, next-to-scan pointer and output register.
   int          m_n    [3] = '{4, 4, 3};
   int          m_mode [3] = '{0, 1, 0};
   int          m_ptr  [3];
   bit          m_valid[3];
   logic [31:0] m_data [3];
   int          m_sel  [3];
   logic [31:0] sb_q [$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(int k);
      for (int j = 0; j < m_n[k]; j++) begin
         int c;
         c = (m_mode[k] == 0) ? (m_ptr[k] + j) % m_n[k] : j;
         if (drv_valid[k][c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ptr[k]   = 0;
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
         m_sel[k]   = 0;
      end
      sb_q.delete();
   endtask

   task automatic idle();
      for (int k = 0; k < 3; k++) begin
         drv_valid[k] = 4'b0000;
         drv_ordy[k]  = 1'b1;
      end
   endtask

   task automatic rand_data();
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++) drv_data[k][c] = $urandom;
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic cycle();
      int         g    [3];
      bit         load [3];
      logic [3:0] exp_ready;
      #1;
      for (int k = 0; k < 3; k++) begin
         g[k]    = model_grant(k);
         load[k] = !m_valid[k] || drv_ordy[k];
         exp_ready = (load[k] && g[k] >= 0) ? 4'(1 << g[k]) : 4'b0000;
         check($sformatf("in_ready[%0d]", k), 32'(obs_ready[k]), 32'(exp_ready));
         check($sformatf("onehot0[%0d]", k), 32'($onehot0(obs_ready[k])), 32'd1);
      end
      if (obs_valid[0] && drv_ordy[0]) begin
         check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) check("sb_data", obs_data[0], sb_q.pop_front());
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (load[k]) begin
            if (g[k] >= 0) begin
               m_valid[k] = 1'b1;
               m_data[k]  = drv_data[k][g[k]];
               m_sel[k]   = g[k];
               if (m_mode[k] == 0) m_ptr[k] = (g[k] + 1) % m_n[k];
               if (k == 0) sb_q.push_back(m_data[k]);
            end else begin
               m_valid[k] = 1'b0;
            end
         end
         check($sformatf("out_valid[%0d]", k), 32'(obs_valid[k]), 32'(m_valid[k]));
         check($sformatf("out_data[%0d]", k), obs_data[k], m_data[k]);
         check($sformatf("out_sel[%0d]", k), 32'(obs_sel[k]), 32'(m_sel[k]));
      end
      @(negedge clk);
   endtask

   // Called at a falling edge; asserts reset, checks the cleared state, releases.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ready[%0d]", k), 32'(obs_ready[k]), 32'd0);
         check($sformatf("rst_valid[%0d]", k), 32'(obs_valid[k]), 32'd0);
         check($sformatf("rst_sel[%0d]", k), 32'(obs_sel[k]), 32'd0);
         check($sformatf("rst_data[%0d]", k), obs_data[k], 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [31:0] held_data;
      logic [1:0]  held_sel;

      idle();
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++) drv_data[k][c] = '0;
      rst_n = 1'b0;
      @(negedge clk);
      apply_reset();

      // Single channel; unselected data left unknown.
      drv_valid[0] = 4'b0100;
      drv_data[0][0] = 'x;
      drv_data[0][1] = 'x;
      drv_data[0][2] = 32'hDEADBEEF;
      drv_data[0][3] = 'x;
      cycle();
      check("single_valid", 32'(a_valid), 32'd1);
      check("single_data", a_data, 32'hDEADBEEF);
      check("single_sel", 32'(a_sel), 32'd2);
      drv_valid[0] = 4'b0000;
      rand_data();
      cycle();
      cycle();
      apply_reset();

      // Round-robin rotation over all channels, then over channels 0 and 3.
      drv_valid[0] = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         cycle();
         check("rr_all_sel", 32'(a_sel), 32'(i % 4));
      end
      drv_valid[0] = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         cycle();
         check("rr_09_sel", 32'(a_sel), (i % 2 == 0) ? 32'd0 : 32'd3);
      end
      drv_valid[0] = 4'b0000;
      cycle();
      cycle();

      // Backpressure: outputs frozen and nothing accepted while stalled.
      drv_valid[0] = 4'b1111;
      rand_data();
      cycle();
      drv_ordy[0] = 1'b0;
      held_data = a_data;
      held_sel  = a_sel;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_ready", 32'(a_ready), 32'd0);
         check("stall_valid", 32'(a_valid), 32'd1);
         check("stall_data", a_data, held_data);
         check("stall_sel", 32'(a_sel), 32'(held_sel));
      end
      drv_ordy[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rand_data();
         cycle();
      end
      drv_valid[0] = 4'b0000;
      cycle();
      cycle();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset while a beat is stalled in the register.
      drv_valid[0] = 4'b1111;
      drv_ordy[0]  = 1'b0;
      rand_data();
      cycle();
      cycle();
      check("pre_reset_valid", 32'(a_valid), 32'd1);
      apply_reset();
      idle();

      // Fixed priority: channel 1 always wins over channel 2.
      drv_valid[1] = 4'b0110;
      for (int i = 0; i < 6; i++) begin
         rand_data();
         cycle();
         check("prio_sel", 32'(b_sel), 32'd1);
         check("prio_valid", 32'(b_valid), 32'd1);
      end
      idle();
      cycle();

      // Three channels, random backpressure: pointer wraps 2 -> 0.
      drv_valid[2] = 4'b0111;
      for (int i = 0; i < 30; i++) begin
         rand_data();
         drv_ordy[2] = ($urandom_range(0, 1) == 1);
         cycle();
         check("n3_sel_range", 32'(c_sel < 2'd3), 32'd1);
      end
      idle();
      cycle();

      // Random traffic on all three instances.
      for (int i = 0; i < 300; i++) begin
         rand_data();
         for (int k = 0; k < 3; k++) begin
            drv_valid[k] = 4'($urandom_range(0, 15));
            drv_ordy[k]  = ($urandom_range(0, 3) != 0);
         end
         cycle();
      end
      idle();
      cycle();
      cycle();
      check("sb_final_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
